// File: rtl/adder_share_arbiter.sv
// ============================================================================
// Module   : adder_share_arbiter
// Summary  : Round-robin sharing of one external multicycle combinational adder
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_share_arbiter #(
  parameter int NREQ          = 4,
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_cin,
  input  logic [WIDTH-1:0]        add_s,
  input  logic                    add_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_s,
  output logic                    rsp_cout,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]     r_state;
  logic [1:0]     w_next;
  logic [IDW-1:0] r_rr_ptr;
  logic [CW-1:0]  r_cnt;
  logic           w_found;
  logic [IDW-1:0] w_winner;
  logic           w_settle_done;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  // Search starts at the pointer so the last served requester is checked last
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = wrap_add(r_rr_ptr, k);
      end
    end
  end

  assign w_settle_done = (r_cnt == CW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found)       w_next = S_SETTLE;
      S_SETTLE: if (w_settle_done) w_next = S_RESP;
      S_RESP:   if (rsp_ready)     w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_found) req_ready[w_winner] = 1'b1;
    busy      = (r_state != S_IDLE);
    rsp_valid = (r_state == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      rsp_id   <= '0;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      rsp_s    <= '0;
      rsp_cout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          add_a   <= req_a[w_winner*WIDTH +: WIDTH];
          add_b   <= req_b[w_winner*WIDTH +: WIDTH];
          add_cin <= req_cin[w_winner];
          rsp_id  <= w_winner;
          r_cnt   <= '0;
        end
        S_SETTLE: begin
          // Adder outputs are only trusted once operands have been stable long enough
          if (w_settle_done) begin
            rsp_s    <= add_s;
            rsp_cout <= add_cout;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: if (rsp_ready) r_rr_ptr <= wrap_add(rsp_id, 1);
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
// ============================================================================
// Module   : tb_adder_share_arbiter
// Summary  : Directed self-checking bench with a delayed model of the shared adder
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adder_share_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_cin;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic         add_cin;
  logic [31:0]  add_s;
  logic         add_cout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_s;
  logic         rsp_cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  int exp_id[6] = '{0, 2, 2, 0, 2, 0};
  bit pat0[6]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  adder_share_arbiter #(.NREQ(4), .WIDTH(32), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Slow adder: result appears SETTLE_CYCLES-1 cycles after the operands change
  always @(posedge clk) {add_cout, add_s} <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_cin[i]        = c;
  endtask

  // Entered mid-cycle in IDLE with requests applied; returns in the next IDLE cycle
  task automatic serve(input string tag, input logic [3:0] er, input logic [1:0] eid,
                       input logic [31:0] es, input logic ec);
    chk({tag, " grant"}, {60'd0, req_ready}, {60'd0, er});
    rsp_ready = 1'b1;
    tick();
    chk({tag, " busy"}, {63'd0, busy}, 64'd1);
    chk({tag, " ready_settle"}, {60'd0, req_ready}, 64'd0);
    tick();
    tick();
    chk({tag, " rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
    chk({tag, " rsp_id"}, {62'd0, rsp_id}, {62'd0, eid});
    chk({tag, " rsp_s"}, {32'd0, rsp_s}, {32'd0, es});
    chk({tag, " rsp_cout"}, {63'd0, rsp_cout}, {63'd0, ec});
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
    repeat (2) tick();
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst req_ready", {60'd0, req_ready}, 64'd0);
    chk("rst add_a", {32'd0, add_a}, 64'd0);
    chk("rst rsp_s", {32'd0, rsp_s}, 64'd0);
    chk("rst rsp_id", {62'd0, rsp_id}, 64'd0);
    rst = 1'b0;
    tick();

    // Single op with full carry ripple
    set_req(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    req_valid = 4'b0001;
    #1 chk("t1 grant", {60'd0, req_ready}, 64'd1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t1 busy", {63'd0, busy}, 64'd1);
    chk("t1 add_a", {32'd0, add_a}, 64'hFFFF_FFFF);
    tick();
    chk("t1 early_valid", {63'd0, rsp_valid}, 64'd0);
    tick();
    chk("t1 rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t1 rsp_s", {32'd0, rsp_s}, 64'd0);
    chk("t1 rsp_cout", {63'd0, rsp_cout}, 64'd1);
    chk("t1 rsp_id", {62'd0, rsp_id}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1 idle", {63'd0, busy}, 64'd0);

    // All four requesting from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 32'h1000_0000, 32'h10, 1'b0);
    set_req(1, 32'h2000_0000, 32'h20, 1'b1);
    set_req(2, 32'h3000_0000, 32'h30, 1'b0);
    set_req(3, 32'h4000_0000, 32'h40, 1'b1);
    req_valid = 4'b1111;
    #1;
    serve("t2 op0", 4'b0001, 2'd0, 32'h1000_0010, 1'b0);
    serve("t2 op1", 4'b0010, 2'd1, 32'h2000_0021, 1'b0);
    serve("t2 op2", 4'b0100, 2'd2, 32'h3000_0030, 1'b0);
    serve("t2 op3", 4'b1000, 2'd3, 32'h4000_0041, 1'b0);
    serve("t2 op4", 4'b0001, 2'd0, 32'h1000_0010, 1'b0);

    // Backpressure on the response channel
    rsp_ready = 1'b0;
    chk("t3 grant", {60'd0, req_ready}, 64'b0010);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      chk("t3 hold_valid", {63'd0, rsp_valid}, 64'd1);
      chk("t3 hold_id", {62'd0, rsp_id}, 64'd1);
      chk("t3 hold_s", {32'd0, rsp_s}, 64'h2000_0021);
      chk("t3 hold_ready", {60'd0, req_ready}, 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t3 drained", {63'd0, busy}, 64'd0);
    chk("t3 next_grant", {60'd0, req_ready}, 64'b0100);
    req_valid = 4'b0000;
    #1 chk("t3 no_valid", {60'd0, req_ready}, 64'd0);
    tick();

    // Sum must only be captured after the slow adder has settled
    set_req(0, 32'h7FFF_FFFF, 32'd1, 1'b1);
    req_valid = 4'b0001;
    #1 chk("t4 grant", {60'd0, req_ready}, 64'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t4 not_yet", {32'd0, rsp_s}, 64'h2000_0021);
    tick();
    chk("t4 rsp_s", {32'd0, rsp_s}, 64'h8000_0001);
    chk("t4 rsp_cout", {63'd0, rsp_cout}, 64'd0);
    chk("t4 rsp_id", {62'd0, rsp_id}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Asynchronous reset while an operation is settling
    set_req(2, 32'h0000_00FF, 32'd1, 1'b0);
    req_valid = 4'b0100;
    #1 chk("t5 grant", {60'd0, req_ready}, 64'b0100);
    tick();
    req_valid = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk("t5 rst_busy", {63'd0, busy}, 64'd0);
    chk("t5 rst_add_a", {32'd0, add_a}, 64'd0);
    chk("t5 rst_rsp_s", {32'd0, rsp_s}, 64'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5 no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    req_valid = 4'b1010;
    #1;
    serve("t5 req1", 4'b0010, 2'd1, 32'h2000_0021, 1'b0);
    serve("t5 req3", 4'b1000, 2'd3, 32'h4000_0041, 1'b0);
    req_valid = 4'b0000;
    tick();

    // req2 always valid, req0 toggling: grants must alternate when both want service
    set_req(0, 32'h0000_0005, 32'd3, 1'b0);
    for (int op = 0; op < 6; op++) begin
      req_valid = {2'b01, 1'b0, pat0[op]};
      #1;
      serve("t6 fair", 4'(1 << exp_id[op]), 2'(exp_id[op]),
            (exp_id[op] == 0) ? 32'h0000_0008 : 32'h0000_0100, 1'b0);
    end
    req_valid = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
